frame_sweeper: RTL and testbench

Raster sweep sequencer between the game-state pixel renderers and the VGA framebuffer adapter. It is paced by a free-running frame timer. On each frame tick it walks every (x, y) screen coordinate into the active renderer and waits out the renderer's fixed latency. It then issues one framebuffer write per pixel and ends each completed sweep with a one-cycle `frame_clk` pulse that drives animation and game-state updates.

---
 rtl/frame_sweeper_if.sv | 29 ++
 rtl/frame_sweeper.sv | 153 +++++++++++++++
 tb/tb_frame_sweeper.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sweeper_if.sv
// Renderer / framebuffer bus between frame_sweeper (master) and its neighbours.
//   x, y        : sweep coordinate to the renderer
//   color_in    : renderer colour for the coordinate issued RENDER_LAT cycles earlier
//   plot*       : framebuffer write enable, coordinate and colour
//   frame_clk   : one-cycle pulse at the end of each completed sweep
//   busy        : sequencer is not idle
//   overrun     : sticky, a frame tick arrived while not idle
interface frame_sweeper_if;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] color_in;
   logic       plot;
   logic [7:0] plot_x;
   logic [7:0] plot_y;
   logic [2:0] plot_color;
   logic       frame_clk;
   logic       busy;
   logic       overrun;

   modport master (
      output x, y, plot, plot_x, plot_y, plot_color, frame_clk, busy, overrun,
      input  color_in
   );

   modport slave (
      input  x, y, plot, plot_x, plot_y, plot_color, frame_clk, busy, overrun,
      output color_in
   );
endinterface

// File: rtl/frame_sweeper.sv
// Raster sweep sequencer: on every frame tick walks all (x, y) through the
// renderer, writes each pixel to the framebuffer once the renderer latency has
// elapsed, and closes the sweep with a one-cycle frame_clk pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : frame_sweeper_if.master (coordinates, colour in, plot port, status)
// Optional feature: define SWEEP_CLEAR_EN to add a post-reset clear pass that
// writes CLEAR_COLOR to every pixel before the first sweep.
module frame_sweeper #(
   parameter int unsigned SCREEN_W    = 160,
   parameter int unsigned SCREEN_H    = 120,
   parameter int unsigned RENDER_LAT  = 1,
   parameter int unsigned FRAME_DIV   = 833334,
   parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
   input  logic            clk,
   input  logic            reset,
   frame_sweeper_if.master bus
);

   localparam int unsigned TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

`ifdef SWEEP_CLEAR_EN
   typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE, S_CLEAR} state_t;
   localparam state_t RST_STATE = S_CLEAR;
`else
   typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t      state_q, state_d;
   logic [TW-1:0] timer_q;
   logic [7:0]  x_q, x_d, y_q, y_d;
   logic [2:0]  drain_q, drain_d;
   logic        ovr_q, ovr_d;

   // Coordinate delay line matching the renderer latency; index RENDER_LAT-1 is stage-out.
   logic [RENDER_LAT-1:0]      pv_q;
   logic [RENDER_LAT-1:0][7:0] px_q;
   logic [RENDER_LAT-1:0][7:0] py_q;

   logic tick, last_x, last_y, tick_overrun;

   assign tick   = (timer_q == TW'(FRAME_DIV - 1));
   assign last_x = (x_q == 8'(SCREEN_W - 1));
   assign last_y = (y_q == 8'(SCREEN_H - 1));

   // Any tick not consumed by IDLE is an overrun (the clear pass excepted).
`ifdef SWEEP_CLEAR_EN
   assign tick_overrun = tick && (state_q != S_IDLE) && (state_q != S_CLEAR);
`else
   assign tick_overrun = tick && (state_q != S_IDLE);
`endif

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      drain_d = drain_q;
      ovr_d   = ovr_q | tick_overrun;
      case (state_q)
         S_IDLE: begin
            x_d     = 8'd0;
            y_d     = 8'd0;
            drain_d = 3'd0;
            if (tick) state_d = S_SWEEP;
         end
`ifdef SWEEP_CLEAR_EN
         S_CLEAR,
`endif
         S_SWEEP: begin
            // Raster advance; the last coordinate wraps both axes back to 0.
            if (last_x) begin
               x_d = 8'd0;
               if (last_y) begin
                  y_d     = 8'd0;
                  state_d = (state_q == S_SWEEP) ? S_DRAIN : S_IDLE;
               end else begin
                  y_d = y_q + 8'd1;
               end
            end else begin
               x_d = x_q + 8'd1;
            end
         end
         S_DRAIN: begin
            if (drain_q == 3'(RENDER_LAT - 1)) begin
               drain_d = 3'd0;
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, timer and pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RST_STATE;
         timer_q <= '0;
         x_q     <= 8'd0;
         y_q     <= 8'd0;
         drain_q <= 3'd0;
         ovr_q   <= 1'b0;
         pv_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= tick ? '0 : timer_q + TW'(1);
         x_q     <= x_d;
         y_q     <= y_d;
         drain_q <= drain_d;
         ovr_q   <= ovr_d;
         pv_q[0] <= (state_q == S_SWEEP);
         px_q[0] <= x_q;
         py_q[0] <= y_q;
         for (int i = 1; i < int'(RENDER_LAT); i++) begin
            pv_q[i] <= pv_q[i-1];
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
         end
      end
   end

   assign bus.x         = x_q;
   assign bus.y         = y_q;
   assign bus.frame_clk = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.overrun   = ovr_q;

`ifdef SWEEP_CLEAR_EN
   // Clear pass writes coordinates straight from the sweep counters.
   logic in_clear;
   assign in_clear       = (state_q == S_CLEAR);
   assign bus.plot       = in_clear | pv_q[RENDER_LAT-1];
   assign bus.plot_x     = in_clear ? x_q : px_q[RENDER_LAT-1];
   assign bus.plot_y     = in_clear ? y_q : py_q[RENDER_LAT-1];
   assign bus.plot_color = in_clear ? CLEAR_COLOR :
                           (pv_q[RENDER_LAT-1] ? bus.color_in : 3'b000);
`else
   assign bus.plot       = pv_q[RENDER_LAT-1];
   assign bus.plot_x     = px_q[RENDER_LAT-1];
   assign bus.plot_y     = py_q[RENDER_LAT-1];
   // Colour is gated so the write port reads all-zero when no pixel is out.
   assign bus.plot_color = pv_q[RENDER_LAT-1] ? bus.color_in : 3'b000;
`endif

endmodule

// File: tb/tb_frame_sweeper.sv
// Scoreboard bench for frame_sweeper on a 4x3 screen.
//   u0: RENDER_LAT=2, FRAME_DIV=40  (basic sweep, pacing, reset mid-sweep)
//   u1: RENDER_LAT=4, FRAME_DIV=40  (long latency)
//   u2: RENDER_LAT=1, FRAME_DIV=10  (short latency, overrun)
// k counts cycles since u0 last left reset; cycle 0 has the timer at 0.
module tb_frame_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rstb;
   int   k;
   int   n_cmp  = 0;
   int   n_fail = 0;

   frame_sweeper_if if0 ();
   frame_sweeper_if if1 ();
   frame_sweeper_if if2 ();

   frame_sweeper #(.SCREEN_W(4), .SCREEN_H(3), .RENDER_LAT(2), .FRAME_DIV(40), .CLEAR_COLOR(3'b000))
      u0 (.clk(clk), .reset(rst0), .bus(if0));
   frame_sweeper #(.SCREEN_W(4), .SCREEN_H(3), .RENDER_LAT(4), .FRAME_DIV(40), .CLEAR_COLOR(3'b000))
      u1 (.clk(clk), .reset(rstb), .bus(if1));
   frame_sweeper #(.SCREEN_W(4), .SCREEN_H(3), .RENDER_LAT(1), .FRAME_DIV(10), .CLEAR_COLOR(3'b000))
      u2 (.clk(clk), .reset(rstb), .bus(if2));

   always @(posedge clk) k <= rst0 ? 0 : k + 1;

   // Renderer model: colour = {x[0], y[1:0]} of the coordinate RENDER_LAT cycles back.
   logic [7:0] hx0 [4], hy0 [4], hx1 [4], hy1 [4], hx2 [4], hy2 [4];
   always @(posedge clk) begin
      hx0[0] <= if0.x; hy0[0] <= if0.y;
      hx1[0] <= if1.x; hy1[0] <= if1.y;
      hx2[0] <= if2.x; hy2[0] <= if2.y;
      for (int i = 1; i < 4; i++) begin
         hx0[i] <= hx0[i-1]; hy0[i] <= hy0[i-1];
         hx1[i] <= hx1[i-1]; hy1[i] <= hy1[i-1];
         hx2[i] <= hx2[i-1]; hy2[i] <= hy2[i-1];
      end
   end
   assign if0.color_in = {hx0[1][0], hy0[1][1:0]};
   assign if1.color_in = {hx1[3][0], hy1[3][1:0]};
   assign if2.color_in = {hx2[0][0], hy2[0][1:0]};

   typedef struct {
      int         k;
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   typedef struct {
      int   k;
      logic ov;
   } frm_t;

   pix_t pq0[$], pq1[$], pq2[$];
   frm_t fq0[$], fq1[$], fq2[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected pulse at k=%0d, expected none", name, k);
   endtask

   // i-th pixel of a 4x3 raster, plotted at cycle kk.
   function automatic pix_t mk_pix(input int kk, input int i);
      pix_t p;
      p.k = kk;
      p.x = 8'(i % 4);
      p.y = 8'(i / 4);
      p.c = {p.x[0], p.y[1:0]};
      return p;
   endfunction

   function automatic frm_t mk_frm(input int kk, input logic ov);
      frm_t f;
      f.k  = kk;
      f.ov = ov;
      return f;
   endfunction

   task automatic chk_pix(input string tag, input pix_t e,
                          input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
      check({tag, ".plot_k"}, 32'(k), 32'(e.k));
      check({tag, ".plot_x"}, 32'(x), 32'(e.x));
      check({tag, ".plot_y"}, 32'(y), 32'(e.y));
      check({tag, ".plot_color"}, 32'(c), 32'(e.c));
   endtask

   task automatic chk_frm(input string tag, input frm_t e, input logic ov);
      check({tag, ".frame_clk_k"}, 32'(k), 32'(e.k));
      check({tag, ".overrun"}, 32'(ov), 32'(e.ov));
   endtask

   // Monitors: pop and compare whenever a DUT presents a plot or frame pulse.
   always @(negedge clk) begin
      if (if0.plot === 1'b1) begin
         if (pq0.size() == 0) unexpected("u0.plot");
         else chk_pix("u0", pq0.pop_front(), if0.plot_x, if0.plot_y, if0.plot_color);
      end
      if (if0.frame_clk === 1'b1) begin
         if (fq0.size() == 0) unexpected("u0.frame_clk");
         else chk_frm("u0", fq0.pop_front(), if0.overrun);
      end
   end

   always @(negedge clk) begin
      if (if1.plot === 1'b1) begin
         if (pq1.size() == 0) unexpected("u1.plot");
         else chk_pix("u1", pq1.pop_front(), if1.plot_x, if1.plot_y, if1.plot_color);
      end
      if (if1.frame_clk === 1'b1) begin
         if (fq1.size() == 0) unexpected("u1.frame_clk");
         else chk_frm("u1", fq1.pop_front(), if1.overrun);
      end
   end

   always @(negedge clk) begin
      if (if2.plot === 1'b1) begin
         if (pq2.size() == 0) unexpected("u2.plot");
         else chk_pix("u2", pq2.pop_front(), if2.plot_x, if2.plot_y, if2.plot_color);
      end
      if (if2.frame_clk === 1'b1) begin
         if (fq2.size() == 0) unexpected("u2.frame_clk");
         else chk_frm("u2", fq2.pop_front(), if2.overrun);
      end
   end

   // Advance to #1 after the edge that starts cycle t (bounded).
   task automatic wait_k(input int t);
      int guard = 0;
      while (k < t && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("wait_k", 32'(k), 32'(t));
   endtask

   initial begin
      rst0 = 1'b1;
      rstb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst0 = 1'b0;
      rstb = 1'b0;

      // Reset state (cycle 0).
      check("rst.x",          32'(if0.x),          32'd0);
      check("rst.y",          32'(if0.y),          32'd0);
      check("rst.plot",       32'(if0.plot),       32'd0);
      check("rst.plot_x",     32'(if0.plot_x),     32'd0);
      check("rst.plot_y",     32'(if0.plot_y),     32'd0);
      check("rst.plot_color", 32'(if0.plot_color), 32'd0);
      check("rst.frame_clk",  32'(if0.frame_clk),  32'd0);
      check("rst.busy",       32'(if0.busy),       32'd0);
      check("rst.overrun",    32'(if0.overrun),    32'd0);

      // u0: ticks at 39, 79, 119 -> plots from tick+3, frame_clk at tick+15.
      for (int m = 0; m < 3; m++) begin
         for (int i = 0; i < 12; i++) pq0.push_back(mk_pix(42 + 40*m + i, i));
         fq0.push_back(mk_frm(54 + 40*m, 1'b0));
      end
      // Fourth sweep (tick 159) is cut by reset after its 5th pixel.
      for (int i = 0; i < 5; i++) pq0.push_back(mk_pix(162 + i, i));

      // u1: tick 39, first plot at tick+5, frame_clk at tick+17.
      for (int i = 0; i < 12; i++) pq1.push_back(mk_pix(44 + i, i));
      fq1.push_back(mk_frm(56, 1'b0));

      // u2: ticks 9, 29, 49 start sweeps; ticks 19, 39 land mid-sweep.
      for (int m = 0; m < 3; m++) begin
         for (int i = 0; i < 12; i++) pq2.push_back(mk_pix(11 + 20*m + i, i));
         fq2.push_back(mk_frm(23 + 20*m, 1'b1));
      end

      wait_k(15);
      check("u2.overrun_pre",  32'(if2.overrun), 32'd0);
      check("u2.busy_sweep",   32'(if2.busy),    32'd1);
      wait_k(21);
      check("u2.overrun_post", 32'(if2.overrun), 32'd1);
      wait_k(54);
      check("u0.busy_done",    32'(if0.busy),    32'd1);
      wait_k(55);
      check("u0.busy_fall",    32'(if0.busy),    32'd0);
      wait_k(65);
      rstb = 1'b1;

      wait_k(166);
      rst0 = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst.plot",      32'(if0.plot),      32'd0);
      check("mid_rst.busy",      32'(if0.busy),      32'd0);
      check("mid_rst.x",         32'(if0.x),         32'd0);
      check("mid_rst.y",         32'(if0.y),         32'd0);
      check("mid_rst.frame_clk", 32'(if0.frame_clk), 32'd0);
      check("mid_rst.overrun",   32'(if0.overrun),   32'd0);
      rst0 = 1'b0;

      // Restart after reset: same timing as the first sweep.
      for (int i = 0; i < 12; i++) pq0.push_back(mk_pix(42 + i, i));
      fq0.push_back(mk_frm(54, 1'b0));
      wait_k(60);

      check("u0.pix_left", 32'(pq0.size()), 32'd0);
      check("u0.frm_left", 32'(fq0.size()), 32'd0);
      check("u1.pix_left", 32'(pq1.size()), 32'd0);
      check("u1.frm_left", 32'(fq1.size()), 32'd0);
      check("u2.pix_left", 32'(pq2.size()), 32'd0);
      check("u2.frm_left", 32'(fq2.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
